// File: rtl/ldarb_pkg.sv
// Shared types for load_reg_arbiter: FSM state encoding, grant counter width and a saturating increment.
package ldarb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/load_register.sv
// Holding register with synchronous active-high reset and load enable.
module load_register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: rotates req so ptr sits at bit 0, then takes the lowest set bit.
module rr_picker #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] idx_c,
  output logic                    any_c
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [2*NREQ-1:0] dbl_c;
  logic [NREQ-1:0]   rot_c;
  logic [31:0]       pos_c;

  assign dbl_c = {req, req};
  assign rot_c = NREQ'(dbl_c >> ptr);
  assign any_c = |req;

  // Walk from the top down so the lowest rotated hit is the one that sticks.
  always_comb begin
    idx_c = '0;
    pos_c = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (rot_c[k-1]) begin
        pos_c = 32'(ptr) + 32'(k - 1);
        if (pos_c >= 32'(NREQ)) pos_c = pos_c - 32'(NREQ);
        idx_c = IDW'(pos_c);
      end
    end
  end

endmodule

// File: rtl/load_reg_arbiter.sv
// Round-robin arbiter sharing one load_register among NREQ requesters.
// Optional per-requester completed-load counters: define LDARB_GRANT_CNT_EN.
module load_reg_arbiter
  import ldarb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_d,
  input  logic                    clr,
  output logic [NREQ-1:0]         gnt,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic                    busy,
  output logic [WIDTH-1:0]        q
`ifdef LDARB_GRANT_CNT_EN
  ,
  output logic [NREQ*CNT_W-1:0]   gnt_cnt
`endif
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   sel_q, sel_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic             busy_q, busy_d;

  logic [IDW-1:0]   sel_inc_c;
  logic [IDW-1:0]   pick_ptr_c;
  logic [IDW-1:0]   pick_idx_c;
  logic             pick_any_c;
  logic             reg_rst_c;
  logic             reg_ld_c;
  logic [WIDTH-1:0] reg_d_c;

  // In DONE the search already starts just past the requester being retired.
  assign sel_inc_c  = (sel_q == IDW'(NREQ - 1)) ? '0 : sel_q + IDW'(1);
  assign pick_ptr_c = (state_q == DONE) ? sel_inc_c : ptr_q;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (req),
    .ptr   (pick_ptr_c),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) ptr_d = sel_inc_c;
        if (clr) begin
          state_d = IDLE;
        end else if (pick_any_c) begin
          state_d = LOAD;
          sel_d   = pick_idx_c;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD:    state_d = clr ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they are flop-driven in the cycle they apply.
  always_comb begin
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    busy_d    = (state_d != IDLE);
    reg_rst_c = rst | clr;
    reg_ld_c  = (state_q == LOAD) && !clr;
    reg_d_c   = req_d[32'(sel_q)*WIDTH +: WIDTH];
    if (state_d == LOAD) gnt_d[sel_d] = 1'b1;
    if (state_d == DONE) begin
      done_d    = 1'b1;
      done_id_d = sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign busy    = busy_q;

  load_register #(.WIDTH(WIDTH)) u_hold (
    .clk (clk),
    .rst (reg_rst_c),
    .ld  (reg_ld_c),
    .d   (reg_d_c),
    .q   (q)
  );

`ifdef LDARB_GRANT_CNT_EN
  logic [NREQ*CNT_W-1:0] cnt_q, cnt_d;

  // Count only loads that reach DONE; clr does not touch the counters.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == DONE)
      cnt_d[32'(sel_q)*CNT_W +: CNT_W] = sat_inc(cnt_q[32'(sel_q)*CNT_W +: CNT_W]);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign gnt_cnt = cnt_q;
`endif

endmodule
